id_ex_stage: RTL

Decode-to-execute pipeline register for the RV32IC core. It sits directly upstream of the ALU. It latches decoded operands and control, and drives the ALU's `a`, `b` and `select` inputs with EX/MEM and MEM/WB forwarding applied. It also detects load-use hazards, inserts bubbles, and honours downstream stall and branch flush.

---
 rtl/id_ex_if.sv | 36 +++
 rtl/id_ex_stage.sv | 64 ++++++
 2 files changed

// File: rtl/id_ex_if.sv
// id_ex_if: decode, forwarding, control and ALU-side signals of the ID/EX stage
interface id_ex_if #(parameter int XLEN = 32, parameter int RA_W = 5);
  logic in_valid;
  logic [XLEN-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [RA_W-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [3:0] in_alu_sel;
  logic in_use_imm, in_uses_rs2, in_reg_write, in_mem_read, in_mem_write;
  logic [RA_W-1:0] ex_mem_rd;
  logic ex_mem_reg_write, ex_mem_mem_read;
  logic [XLEN-1:0] ex_mem_res;
  logic [RA_W-1:0] mem_wb_rd;
  logic mem_wb_reg_write;
  logic [XLEN-1:0] mem_wb_data;
  logic hold, flush;
  logic stall_out, out_valid;
  logic [XLEN-1:0] alu_a, alu_b, store_data, out_pc;
  logic [3:0] alu_select;
  logic [RA_W-1:0] out_rd;
  logic out_reg_write, out_mem_read, out_mem_write;
  modport master (
    output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm, in_rs1_addr, in_rs2_addr, in_rd_addr,
           in_alu_sel, in_use_imm, in_uses_rs2, in_reg_write, in_mem_read, in_mem_write,
           ex_mem_rd, ex_mem_reg_write, ex_mem_mem_read, ex_mem_res,
           mem_wb_rd, mem_wb_reg_write, mem_wb_data, hold, flush,
    input  stall_out, out_valid, alu_a, alu_b, alu_select, store_data, out_pc, out_rd,
           out_reg_write, out_mem_read, out_mem_write
  );
  modport slave (
    input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm, in_rs1_addr, in_rs2_addr, in_rd_addr,
           in_alu_sel, in_use_imm, in_uses_rs2, in_reg_write, in_mem_read, in_mem_write,
           ex_mem_rd, ex_mem_reg_write, ex_mem_mem_read, ex_mem_res,
           mem_wb_rd, mem_wb_reg_write, mem_wb_data, hold, flush,
    output stall_out, out_valid, alu_a, alu_b, alu_select, store_data, out_pc, out_rd,
           out_reg_write, out_mem_read, out_mem_write
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use bubble insertion
module id_ex_stage #(parameter int XLEN = 32, parameter int RA_W = 5) (
  input logic clk,
  input logic rst,
  id_ex_if.slave bus
);
  logic v, ui, rw, mr, mw;
  logic [XLEN-1:0] pc, d1, d2, imm, r1, r2;
  logic [RA_W-1:0] a1, a2, rd;
  logic [3:0] sel;
  logic f1e, f2e, f1w, f2w, hazard;
  // forwarding select, load-use detection and output drive
  always_comb begin
    f1e = bus.ex_mem_reg_write && !bus.ex_mem_mem_read && (bus.ex_mem_rd != '0) && (bus.ex_mem_rd == a1);
    f2e = bus.ex_mem_reg_write && !bus.ex_mem_mem_read && (bus.ex_mem_rd != '0) && (bus.ex_mem_rd == a2);
    f1w = bus.mem_wb_reg_write && (bus.mem_wb_rd != '0) && (bus.mem_wb_rd == a1);
    f2w = bus.mem_wb_reg_write && (bus.mem_wb_rd != '0) && (bus.mem_wb_rd == a2);
    r1 = f1e ? bus.ex_mem_res : f1w ? bus.mem_wb_data : d1;
    r2 = f2e ? bus.ex_mem_res : f2w ? bus.mem_wb_data : d2;
    hazard = v && mr && (rd != '0) && bus.in_valid &&
             ((rd == bus.in_rs1_addr) || (bus.in_uses_rs2 && (rd == bus.in_rs2_addr)));
    bus.stall_out = bus.hold | hazard;
    bus.out_valid = v;
    bus.alu_a = r1;
    bus.alu_b = ui ? imm : r2;
    bus.store_data = r2;
    bus.alu_select = sel;
    bus.out_pc = pc;
    bus.out_rd = rd;
    bus.out_reg_write = v & rw;
    bus.out_mem_read = v & mr;
    bus.out_mem_write = v & mw;
  end
  // stage register: reset > flush > hold (refreshing retiring operands) > bubble > capture
  always_ff @(posedge clk) begin
    if (rst) begin
      {v, ui, rw, mr, mw} <= '0;
      {pc, d1, d2, imm} <= '0;
      {a1, a2, rd} <= '0;
      sel <= '0;
    end else if (bus.flush) begin
      {v, rw, mr, mw} <= '0;
    end else if (bus.hold) begin
      if (f1w) d1 <= bus.mem_wb_data;
      if (f2w) d2 <= bus.mem_wb_data;
    end else if (hazard) begin
      {v, rw, mr, mw} <= '0;
    end else begin
      v <= bus.in_valid;
      pc <= bus.in_pc;
      d1 <= bus.in_rs1_data;
      d2 <= bus.in_rs2_data;
      imm <= bus.in_imm;
      a1 <= bus.in_rs1_addr;
      a2 <= bus.in_rs2_addr;
      rd <= bus.in_rd_addr;
      sel <= bus.in_alu_sel;
      ui <= bus.in_use_imm;
      rw <= bus.in_reg_write;
      mr <= bus.in_mem_read;
      mw <= bus.in_mem_write;
    end
  end
endmodule
